epidemic_ingress: RTL and testbench
===================================

# epidemic_ingress

Per-port ingress stage for a grid node: accepts single-flit 8-bit packets from one neighbour link over a valid/ready handshake, suppresses epidemic duplicates, and buffers survivors in a small FIFO. It presents the survivors to the node's routing core through a second valid/ready handshake. Each node instantiates one copy per side (l/r/t/b), directly upstream of the node's forwarding logic.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ID_W, 4: packet-ID width; the ID is `i_data[7:8-ID_W]`; range 1..7.
- CLR_PERIOD, 256: epoch length in cycles between seen-table flushes; at least 2.
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- i_valid  in  1  link flit valid.
- i_data  in  8  link flit.
- o_ready  out  1  ingress can accept a link flit.
- o_valid  out  1  buffered flit available to the core.
- o_data  out  8  head-of-FIFO flit.
- i_ready  in  1  core accepts the head flit.
- o_drop_cnt  out  8  saturating count of duplicates dropped.

## Operation
- Link transfer: occurs when `i_valid && o_ready`. Core transfer: occurs when `o_valid && i_ready`.
- `o_ready = !full`. It has no combinational path from `i_ready`, so a pop does not free a slot in the same cycle.
- `o_valid = !empty`. `o_data = mem[rd_ptr]`, driven straight from the FIFO storage. While empty, `o_data` is don't-care.
- Seen table: 2^ID_W bits, `seen[id]`.
- Accepted flit with `seen[id]==1`:
  - The flit is discarded and not written to the FIFO.
  - `o_drop_cnt` increments and saturates at 255.
- Accepted flit with `seen[id]==0`:
  - The flit is written at `wr_ptr`.
  - `seen[id]` is set.
- Epoch counter: counts 0..CLR_PERIOD-1 and then wraps to 0. On the cycle it equals CLR_PERIOD-1, every seen bit is cleared at the clock edge.
- Simultaneous flush and accept: the lookup uses the pre-flush table. After the edge, only the accepted flit's `seen[id]` is 1, and only if the flit was written.
- Duplicate lookup and write decision use current-cycle values only; nothing is pipelined.
- Simultaneous push and pop while neither full nor empty: both happen and the occupancy is unchanged.
- Pointers have log2(DEPTH)+1 bits; full/empty are decided by comparing the MSBs. The pointers wrap naturally.
- The FIFO preserves order: surviving flits leave in arrival order.

## Timing
- Reset (async assert, sync release) sets:
  - `o_ready=1`, `o_valid=0`, `o_drop_cnt=0`
  - pointers 0, seen table all 0, epoch counter 0.
- Latency: a flit accepted at edge N gives `o_valid=1` with that flit on `o_data` in cycle N+1.
- Pop at edge N: the next entry (if any) appears on `o_data` in cycle N+1.
- A full FIFO deasserts `o_ready` in the cycle after the filling write. `o_ready` reasserts in the cycle after the first pop.
- Duplicate drops never stall: a dropped flit is still accepted (handshake completes) even though it uses no FIFO slot. Drops are only possible while `o_ready=1`.
- Reset mid-operation: all buffered flits and seen history are lost. No output glitches beyond the async clear.

## Configuration
- EPI_DEDUP_EN defined:
  - Seen table, epoch counter and drop logic are present, as described above.
- EPI_DEDUP_EN undefined:
  - Every accepted flit is written to the FIFO.
  - The seen table and epoch counter are not synthesized.
  - `o_drop_cnt` is tied to 0.
  - All other behaviour and timing are identical.

## Test plan
- Reset then single flit: push `8'h3A` with `i_ready=1`. Required: `o_valid=1`, `o_data=8'h3A` one cycle later, then empty. `o_drop_cnt=0`.
- Duplicate drop (EPI_DEDUP_EN): push `8'h51`, then `8'h5F` (same ID 5). Required: only `8'h51` emerges and `o_drop_cnt=1`.
- Full/backpressure: `i_ready=0`, push IDs 1,2,3,4 (DEPTH=4). Required: `o_ready=0` after the 4th write and a 5th flit held by the source. Then raise `i_ready`: data drains as 1,2,3,4 and `o_ready` returns one cycle after the first pop.
- Epoch flush: push ID 7, wait for the counter to wrap (CLR_PERIOD=8 in the bench), push ID 7 again. Required: the second copy is delivered.
- Flush/accept collision: accept ID 9 exactly on the flush cycle. Required: it is delivered. A repeat of ID 9 in the next cycle is dropped.
- Without EPI_DEDUP_EN: push `8'h51` twice. Required: both delivered and `o_drop_cnt=0`.

Source files
------------

// File: rtl/epidemic_ingress.sv
// epidemic_ingress: per-port link ingress with epidemic duplicate suppression feeding a small FIFO.
// Define EPI_DEDUP_EN to build the seen table, epoch flush and drop counter; otherwise every flit is buffered.
module epidemic_ingress #(
    parameter int DEPTH      = 4,
    parameter int ID_W       = 4,
    parameter int CLR_PERIOD = 256
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    input  logic       i_ready,
    output logic [7:0] o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("epidemic_ingress: DEPTH must be a power of two, at least 2");
    end
    if (ID_W < 1 || ID_W > 7) begin : g_bad_id_w
        $error("epidemic_ingress: ID_W must be in 1..7");
    end
    if (CLR_PERIOD < 2) begin : g_bad_clr
        $error("epidemic_ingress: CLR_PERIOD must be at least 2");
    end

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        full;
    logic        empty;
    logic        link_xfer;
    logic        core_xfer;
    logic        push;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign o_ready   = !full;
    assign o_valid   = !empty;
    assign o_data    = mem[rd_ptr[AW-1:0]];
    assign link_xfer = i_valid && o_ready;
    assign core_xfer = o_valid && i_ready;

`ifdef EPI_DEDUP_EN
    localparam int EW = $clog2(CLR_PERIOD);

    logic [ID_W-1:0]        id;
    logic [(1 << ID_W)-1:0] seen;
    logic [EW-1:0]          epoch;
    logic                   flush;
    logic                   dup;

    assign id    = i_data[7 -: ID_W];
    assign dup   = seen[id];
    assign flush = (epoch == EW'(CLR_PERIOD - 1));
    assign push  = link_xfer && !dup;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            epoch      <= '0;
            seen       <= '0;
            o_drop_cnt <= '0;
        end else begin
            epoch <= flush ? '0 : epoch + EW'(1);
            // Flush first, then mark: on a collision only the newly written ID survives the flush.
            if (flush)
                seen <= '0;
            if (push)
                seen[id] <= 1'b1;
            if (link_xfer && dup && o_drop_cnt != 8'hFF)
                o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end
`else
    assign push       = link_xfer;
    assign o_drop_cnt = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (core_xfer)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: tb/tb_epidemic_ingress.sv
// Directed bench for epidemic_ingress (DEPTH=4, ID_W=4, CLR_PERIOD=8); follows EPI_DEDUP_EN if defined.
module tb_epidemic_ingress;
`ifdef EPI_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic       i_ready;
    logic [7:0] o_drop_cnt;

    int vecs  = 0;
    int errs  = 0;
    int edges = 0;

    bit fl;
    bit acc;
    bit m_seen;
    int m_drop;

    epidemic_ingress #(
        .DEPTH(4),
        .ID_W(4),
        .CLR_PERIOD(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_valid(o_valid),
        .o_data(o_data),
        .i_ready(i_ready),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    // Idle until just after an edge on which the epoch flush fired.
    task automatic align();
        do step(); while (edges % 8 != 0);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_ready = 1'b0;
        #12;
        chk("rst_ready", {7'b0, o_ready}, 8'h01);
        chk("rst_valid", {7'b0, o_valid}, 8'h00);
        chk("rst_drop",  o_drop_cnt,      8'h00);
        @(negedge clk);
        rstn  = 1'b1;
        edges = 0;

        // single flit
        i_valid = 1'b1; i_data = 8'h3A; i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        chk("t1_valid", {7'b0, o_valid}, 8'h01);
        chk("t1_data",  o_data,          8'h3A);
        step();
        chk("t1_empty", {7'b0, o_valid}, 8'h00);
        chk("t1_drop",  o_drop_cnt,      8'h00);

        // same ID twice
        align();
        i_ready = 1'b0; i_valid = 1'b1; i_data = 8'h51;
        step();
        chk("t2_data0", o_data, 8'h51);
        i_data = DEDUP ? 8'h5F : 8'h51;
        step();
        chk("t2_ready", {7'b0, o_ready}, 8'h01);
        chk("t2_drop",  o_drop_cnt,      DEDUP ? 8'h01 : 8'h00);
        i_valid = 1'b0; i_ready = 1'b1;
        step();
        chk("t2_valid1", {7'b0, o_valid}, DEDUP ? 8'h00 : 8'h01);
        if (!DEDUP) begin
            chk("t2_data1", o_data, 8'h51);
            step();
            chk("t2_empty", {7'b0, o_valid}, 8'h00);
        end

        // fill, backpressure, drain in order
        align();
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 8'h10; step(); chk("t3_rdy1", {7'b0, o_ready}, 8'h01);
        i_data = 8'h20; step(); chk("t3_rdy2", {7'b0, o_ready}, 8'h01);
        i_data = 8'h30; step(); chk("t3_rdy3", {7'b0, o_ready}, 8'h01);
        i_data = 8'h40; step(); chk("t3_full", {7'b0, o_ready}, 8'h00);
        i_data = 8'h50;
        step();
        chk("t3_held_rdy",  {7'b0, o_ready}, 8'h00);
        chk("t3_held_head", o_data,          8'h10);
        i_ready = 1'b1;
        step();
        chk("t3_pop1_rdy",  {7'b0, o_ready}, 8'h01);
        chk("t3_pop1_data", o_data,          8'h20);
        step();
        chk("t3_d3", o_data, 8'h30);
        i_valid = 1'b0;
        step(); chk("t3_d4", o_data, 8'h40);
        step(); chk("t3_d5", o_data, 8'h50);
        step(); chk("t3_empty", {7'b0, o_valid}, 8'h00);

        if (DEDUP) begin
            // epoch flush re-admits an ID
            align();
            i_valid = 1'b1; i_data = 8'h70;
            step();
            chk("t4_first", o_data, 8'h70);
            i_data = 8'h71;
            step();
            chk("t4_dup_valid", {7'b0, o_valid}, 8'h00);
            chk("t4_dup_drop",  o_drop_cnt,      8'h02);
            i_valid = 1'b0;
            align();
            i_valid = 1'b1; i_data = 8'h77;
            step();
            i_valid = 1'b0;
            chk("t4_again_valid", {7'b0, o_valid}, 8'h01);
            chk("t4_again_data",  o_data,          8'h77);
            step();

            // accept on the flush edge itself
            while (edges % 8 != 7) step();
            i_valid = 1'b1; i_data = 8'h9A;
            step();
            chk("t5_coll_data", o_data, 8'h9A);
            i_data = 8'h9B;
            step();
            chk("t5_rep_valid", {7'b0, o_valid}, 8'h00);
            chk("t5_rep_drop",  o_drop_cnt,      8'h03);
            i_data = 8'h7E;
            step();
            i_valid = 1'b0;
            chk("t5_other_data", o_data, 8'h7E);
            step();
            chk("t5_empty", {7'b0, o_valid}, 8'h00);
        end

        // long stream of one ID: drop counter saturates
        m_seen = 1'b0;
        m_drop = DEDUP ? 3 : 0;
        i_valid = 1'b1; i_data = 8'hE5; i_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            fl  = (edges % 8 == 7);
            acc = !(DEDUP && m_seen);
            if (!acc && m_drop < 255) m_drop++;
            m_seen = fl ? acc : (m_seen | acc);
            step();
        end
        i_valid = 1'b0;
        chk("t6_sat_drop", o_drop_cnt, 8'(m_drop));
        chk("t6_sat_hand", o_drop_cnt, DEDUP ? 8'hFF : 8'h00);
        chk("t6_ready",    {7'b0, o_ready}, 8'h01);
        step();

        // reset mid-operation
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 8'hA1; step();
        i_data = 8'hB2; step();
        i_valid = 1'b0;
        chk("t7_pre_valid", {7'b0, o_valid}, 8'h01);
        #2;
        rstn = 1'b0;
        #1;
        chk("t7_rst_valid", {7'b0, o_valid}, 8'h00);
        chk("t7_rst_ready", {7'b0, o_ready}, 8'h01);
        chk("t7_rst_drop",  o_drop_cnt,      8'h00);
        @(negedge clk);
        rstn  = 1'b1;
        edges = 0;
        i_valid = 1'b1; i_data = 8'hA1; i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        chk("t7_after_data", o_data, 8'hA1);
        chk("t7_after_drop", o_drop_cnt, 8'h00);
        step();
        chk("t7_empty", {7'b0, o_valid}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
